// File: rtl/keypad_scan.sv
// keypad_scan -- 4x3 matrix keypad scanner with per-frame debounce.
//
// Drives one column low at a time, samples the rows on the last dwell cycle
// of each column, and reduces each 3-column frame to a single key code, or to
// NONE when zero keys or more than one key are down. A debounce FSM
// evaluates each frame result. It accepts a press or a release only after
// DEBOUNCE_FRAMES consecutive agreeing frames.
//
// Optional macro KEYPAD_AUTOREPEAT_EN: while a key is held, the outputs
// blink low for one cycle after REPEAT_DELAY cycles and then every
// REPEAT_PERIOD cycles. Each time they come back, key_valid strobes.
//
// Ports:
//   clk        1 kHz system clock
//   rst        asynchronous, active-high reset
//   key_row    row sense, active-low, bit0 = top row
//   key_col    column drive, active-low one-cold, bit0 = left column
//   keypad     held one-hot digit (bit n = digit n)
//   key_func   bit0 = '*' held, bit1 = '#' held
//   key_code   0-9 digit, 10 '*', 11 '#', 15 none
//   key_valid  one-cycle strobe per accepted press or repeat
module keypad_scan #(
  parameter int DWELL           = 2,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [9:0] keypad,
  output logic [1:0] key_func,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [3:0]       NONE       = 4'hF;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    if (r != 2'd3) k = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
    else if (c == 2'd0) k = 4'd10;
    else if (c == 2'd1) k = 4'd0;
    else k = 4'd11;
    return k;
  endfunction

  function automatic logic [9:0] dig_hot(input logic [3:0] k);
    return (k <= 4'd9) ? (10'd1 << k) : 10'd0;
  endfunction

  function automatic logic [1:0] func_hot(input logic [3:0] k);
    return (k == 4'd10) ? 2'b01 : (k == 4'd11) ? 2'b10 : 2'b00;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [1:0]       hits_q, hits_d;   // keys seen this frame, saturating at 2
  logic [3:0]       acc_q, acc_d;     // code of the first key seen this frame
  logic [2:0]       key_col_q, key_col_d;
  logic [9:0]       keypad_q, keypad_d;
  logic [1:0]       key_func_q, key_func_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_next, rpt_thr;
  logic             rpt_first_q, rpt_first_d;  // first repeat already issued
  logic             gap_q, gap_d;              // outputs are in their blank cycle
`else
  localparam int unused_rpt_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

  logic       sample, frame_end;
  logic [2:0] nlow, hit_sum;
  logic [1:0] row_idx, hits_new;
  logic [3:0] code_new, result;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    hits_d      = hits_q;
    acc_d       = acc_q;
    keypad_d    = keypad_q;
    key_func_d  = key_func_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    result      = NONE;
    cnt_inc     = cnt_q + 1'b1;

    // Column scan: advance column after the sampling cycle.
    sample    = (dwell_q == DWELL_LAST);
    frame_end = sample && (col_idx_q == 2'd2);
    if (sample) begin
      dwell_d   = '0;
      col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
    key_col_d = ~(3'b001 << col_idx_d);

    // Row sense for the driven column.
    nlow    = '0;
    row_idx = '0;
    for (int r = 0; r < 4; r++) begin
      if (!key_row[r]) begin
        nlow    = nlow + 3'd1;
        row_idx = 2'(r);
      end
    end
    hit_sum  = {1'b0, hits_q} + nlow;
    hits_new = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    code_new = (hits_q == 2'd0 && nlow == 3'd1) ? key_map(row_idx, col_idx_q) : acc_q;

    if (sample) begin
      if (frame_end) begin
        result = (hits_new == 2'd1) ? code_new : NONE;
        hits_d = '0;
        acc_d  = NONE;
      end else begin
        hits_d = hits_new;
        acc_d  = code_new;
      end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    gap_d       = 1'b0;
    rpt_next    = rpt_cnt_q + 1'b1;
    rpt_thr     = rpt_first_q ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
    if (gap_q) begin
      keypad_d    = dig_hot(cand_q);
      key_func_d  = func_hot(cand_q);
      key_valid_d = 1'b1;
    end
    // Counter only runs in HELD; RELEASE_WAIT leaves it paused.
    if (state_q == HELD) begin
      if (rpt_next == rpt_thr) begin
        keypad_d    = '0;
        key_func_d  = '0;
        gap_d       = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_next;
      end
    end
`endif

    if (frame_end) begin
      unique case (state_q)
        IDLE: if (result != NONE) begin
          cand_d  = result;
          cnt_d   = CNT_W'(1);
          state_d = PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (result == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d     = HELD;
              keypad_d    = dig_hot(cand_q);
              key_func_d  = func_hot(cand_q);
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt_cnt_d   = '0;
              rpt_first_d = 1'b0;
              gap_d       = 1'b0;
`endif
            end
          end else if (result == NONE) begin
            state_d = IDLE;
          end else begin
            cand_d = result;
            cnt_d  = CNT_W'(1);
          end
        end
        HELD: if (result != cand_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
        RELEASE_WAIT: begin
          if (result == cand_q) begin
            state_d = HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d     = IDLE;
              keypad_d    = '0;
              key_func_d  = '0;
              key_code_d  = NONE;
              key_valid_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt_cnt_d   = '0;
              rpt_first_d = 1'b0;
              gap_d       = 1'b0;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_idx_q   <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      cand_q      <= NONE;
      hits_q      <= '0;
      acc_q       <= NONE;
      key_col_q   <= 3'b110;
      keypad_q    <= '0;
      key_func_q  <= '0;
      key_code_q  <= NONE;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b0;
      gap_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      hits_q      <= hits_d;
      acc_q       <= acc_d;
      key_col_q   <= key_col_d;
      keypad_q    <= keypad_d;
      key_func_q  <= key_func_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      gap_q       <= gap_d;
`endif
    end
  end

  assign key_col   = key_col_q;
  assign keypad    = keypad_q;
  assign key_func  = key_func_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Testbench for keypad_scan: a matrix model turns pressed keys into row
// levels from the driven column; expected accepts are queued by the stimulus
// and popped by a monitor on every key_valid strobe.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [9:0] keypad;
  logic [1:0] key_func;
  logic [3:0] key_code;
  logic       key_valid;

  logic [3:0][2:0] down;  // down[row][col]

  typedef struct packed {
    logic [9:0] kp;
    logic [1:0] fn;
    logic [3:0] code;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  keypad_scan #(.DWELL(2), .DEBOUNCE_FRAMES(4), .REPEAT_DELAY(500), .REPEAT_PERIOD(200)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
    .keypad(keypad), .key_func(key_func), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (down[r][c] && !key_col[c]) key_row[r] = 1'b0;
  end

  // Scoreboard monitor: every strobe must match the oldest queued accept.
  always @(negedge clk) begin
    if (!rst && key_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got kp=%b fn=%b code=%0d, want no strobe",
                 keypad, key_func, key_code);
      end else begin
        mon_e = exp_q.pop_front();
        if ({keypad, key_func, key_code} !== mon_e) begin
          fails++;
          $display("FAIL strobe_value: got kp=%b fn=%b code=%0d, want kp=%b fn=%b code=%0d",
                   keypad, key_func, key_code, mon_e.kp, mon_e.fn, mon_e.code);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] k);
    exp_t e;
    e.kp   = (k <= 4'd9) ? (10'd1 << k) : 10'd0;
    e.fn   = (k == 4'd10) ? 2'b01 : (k == 4'd11) ? 2'b10 : 2'b00;
    e.code = k;
    return e;
  endfunction

  // Wait up to maxc negedges for the outputs to equal e.
  task automatic wait_out(input string name, input exp_t e, input int maxc);
    bit ok = 1'b0;
    for (int n = 1; n <= maxc; n++) begin
      @(negedge clk);
      if ({keypad, key_func, key_code} === e) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got kp=%b fn=%b code=%0d, want kp=%b fn=%b code=%0d within %0d cycles",
               name, keypad, key_func, key_code, e.kp, e.fn, e.code, maxc);
    end
  endtask

  logic [2:0] col_seq [6];
  exp_t idle_e;
  bit   bad;
  int   gaps, first_gap;

  initial begin
    col_seq = '{3'b110, 3'b101, 3'b101, 3'b011, 3'b011, 3'b110};
    idle_e  = mk(4'hF);
    down = '0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_col", {13'd0, key_col}, 16'h0006);
    chk("rst_keypad", {6'd0, keypad}, 16'h0000);
    chk("rst_func", {14'd0, key_func}, 16'h0000);
    chk("rst_code", {12'd0, key_code}, 16'h000F);
    chk("rst_valid", {15'd0, key_valid}, 16'h0000);

    // Column sequence after release
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("col_seq%0d", i), {13'd0, key_col}, {13'd0, col_seq[i]});
    end

    // '5' held for 10 frames, then released
    down[1][1] = 1'b1;
    exp_q.push_back(mk(4'd5));
    wait_out("press_5", mk(4'd5), 31);
    repeat (34) @(negedge clk);
    down = '0;
    wait_out("release_5", idle_e, 31);
    repeat (12) @(negedge clk);

    // '7' bouncing every frame: nothing may be accepted
    bad = 1'b0;
    for (int f = 0; f < 8; f++) begin
      down[2][0] = (f % 2 == 0);
      repeat (6) begin
        @(negedge clk);
        if (keypad != 10'd0 || key_code != 4'hF) bad = 1'b1;
      end
    end
    down = '0;
    repeat (30) begin
      @(negedge clk);
      if (keypad != 10'd0 || key_code != 4'hF) bad = 1'b1;
    end
    chk("bounce_7_quiet", {15'd0, bad}, 16'h0000);

    // '1'+'2' together rejected, then '*' alone accepted
    down[0][0] = 1'b1;
    down[0][1] = 1'b1;
    bad = 1'b0;
    repeat (48) begin
      @(negedge clk);
      if (keypad != 10'd0 || key_func != 2'd0 || key_code != 4'hF) bad = 1'b1;
    end
    chk("multi_key_quiet", {15'd0, bad}, 16'h0000);
    down = '0;
    down[3][0] = 1'b1;
    exp_q.push_back(mk(4'd10));
    wait_out("press_star", mk(4'd10), 31);
    chk("star_keypad_zero", {6'd0, keypad}, 16'h0000);
    repeat (10) @(negedge clk);
    down = '0;
    wait_out("release_star", idle_e, 31);
    repeat (12) @(negedge clk);

    // '3' held, reset pulse, re-accept
    down[0][2] = 1'b1;
    exp_q.push_back(mk(4'd3));
    wait_out("press_3", mk(4'd3), 31);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_keypad", {6'd0, keypad}, 16'h0000);
    chk("midrst_code", {12'd0, key_code}, 16'h000F);
    chk("midrst_col", {13'd0, key_col}, 16'h0006);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(mk(4'd3));
    wait_out("reaccept_3", mk(4'd3), 31);
    repeat (6) @(negedge clk);
    down = '0;
    wait_out("release_3", idle_e, 31);
    repeat (12) @(negedge clk);

    // '9' held for 1200 cycles
    down[2][2] = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
    repeat (5) exp_q.push_back(mk(4'd9));
`else
    exp_q.push_back(mk(4'd9));
`endif
    wait_out("press_9", mk(4'd9), 31);
    gaps = 0;
    first_gap = -1;
    for (int k = 1; k < 1200; k++) begin
      @(negedge clk);
      if (keypad == 10'd0) begin
        gaps++;
        if (first_gap < 0) first_gap = k;
      end
      if (key_code != 4'd9) bad = 1'b1;
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("repeat_gaps", 16'(gaps), 16'd4);
    chk("repeat_first_gap", 16'(first_gap), 16'd500);
`else
    chk("repeat_gaps", 16'(gaps), 16'd0);
`endif
    chk("hold_9_code_steady", {15'd0, bad}, 16'h0000);
    down = '0;
    wait_out("release_9", idle_e, 31);
    repeat (20) @(negedge clk);

    chk("strobes_outstanding", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
